// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads instruction memory over req/ack and buffers words for decode.
// One cycle from imem_ack to instr_valid; fetch stalls while the buffer plus in-flight read is full.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic [31:0] jump_pc
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    state_t          state;
    state_t          state_nxt;
    logic [31:0]     fetch_pc;
    logic [31:0]     fetch_pc_nxt;
    logic [31:0]     addr_nxt;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_after;
    logic [CW:0]     occupied;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    entry_t          fifo_mem [DEPTH];
    entry_t          head;

    logic            ack_ok;
    logic            push;
    logic            pop;
    logic            room;
    logic            room_after;
    logic [31:0]     jump_pc_plus4;
    logic [31:0]     jump_target;
    logic            unused_pc_bits;

    assign jump_pc_plus4  = jump_pc + 32'd4;
    assign jump_target    = {jump_pc_plus4[31:28], jump_index, 2'b00};
    assign unused_pc_bits = ^jump_pc_plus4[27:0];

    // An ack only counts while a request is actually outstanding.
    assign ack_ok = imem_ack & imem_req;
    assign push   = (state == REQ) & ack_ok & ~jump;
    assign pop    = instr_valid & instr_ready & ~jump;

    assign count_after = count + CW'(push) - CW'(pop);
    assign occupied    = {1'b0, count} + {{CW{1'b0}}, (state == REQ)};
    assign room        = occupied < (CW + 1)'(DEPTH);
    assign room_after  = count_after < CW'(DEPTH);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (jump || room) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (jump && !ack_ok) begin
                    state_nxt = DROP;
                end else if (push && !room_after) begin
                    state_nxt = IDLE;
                end
            end
            DROP: begin
                // A completing stale read hands over to the newest target.
                if (ack_ok) begin
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        imem_req = 1'b0;
        if (state == REQ || state == DROP) begin
            imem_req = 1'b1;
        end
    end

    // The address only moves when a fresh request is about to be launched.
    always_comb begin
        fetch_pc_nxt = fetch_pc;
        addr_nxt     = imem_addr;
        if (jump) begin
            fetch_pc_nxt = jump_target;
        end else if (push) begin
            fetch_pc_nxt = fetch_pc + 32'd4;
        end
        if (state_nxt == REQ && (state != REQ || ack_ok)) begin
            addr_nxt = fetch_pc_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc  <= RESET_PC;
            imem_addr <= RESET_PC;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
        end else begin
            fetch_pc  <= fetch_pc_nxt;
            imem_addr <= addr_nxt;
            if (jump) begin
                count  <= '0;
                rd_ptr <= wr_ptr;
            end else begin
                count <= count_after;
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else if (push) begin
            fifo_mem[wr_ptr] <= '{pc: fetch_pc, word: imem_rdata};
        end
    end

    assign head        = fifo_mem[rd_ptr];
    assign instr_valid = (count != '0);
    assign instr       = head.word;
    assign instr_pc    = head.pc;
    assign opcode      = head.word[31:26];
    assign funct       = head.word[5:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random traffic against a queue-based model.
module tb_instr_fetch;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] jump_pc;

    int checks   = 0;
    int failures = 0;

    instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .opcode      (opcode),
        .funct       (funct),
        .jump        (jump),
        .jump_index  (jump_index),
        .jump_pc     (jump_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: queue of buffered PCs, an outstanding-read flag and a discard flag.
    logic [31:0] mq[$];
    bit          m_busy;
    bit          m_drop;
    logic [31:0] m_fpc;
    logic [31:0] m_addr;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] target_of(input logic [31:0] pc, input logic [25:0] idx);
        logic [31:0] nxt;
        nxt = pc + 32'd4;
        return (nxt & 32'hF000_0000) | ({6'b0, idx} << 2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic model_reset();
        mq.delete();
        m_busy = 1'b0;
        m_drop = 1'b0;
        m_fpc  = RESET_PC;
        m_addr = RESET_PC;
    endtask

    task automatic model_step();
        int n0;
        bit acc;
        bit pop;
        n0  = mq.size();
        acc = imem_ack && m_busy;
        pop = instr_ready && (n0 > 0);
        if (jump) begin
            mq.delete();
            m_fpc = target_of(jump_pc, jump_index);
            if (!m_busy) begin
                m_busy = 1'b1;
                m_drop = 1'b0;
                m_addr = m_fpc;
            end else if (acc) begin
                m_drop = 1'b0;
                m_addr = m_fpc;
            end else begin
                m_drop = 1'b1;
            end
        end else begin
            if (pop) void'(mq.pop_front());
            if (!m_busy) begin
                if (n0 < DEPTH) begin
                    m_busy = 1'b1;
                    m_addr = m_fpc;
                end
            end else if (acc && m_drop) begin
                m_drop = 1'b0;
                m_addr = m_fpc;
            end else if (acc) begin
                mq.push_back(m_fpc);
                m_fpc = m_fpc + 32'd4;
                if (mq.size() < DEPTH) m_addr = m_fpc;
                else m_busy = 1'b0;
            end
        end
    endtask

    task automatic check_outputs();
        if (!rst_n) return;
        chk1("imem_req", imem_req, m_busy);
        if (m_busy) chk("imem_addr", imem_addr, m_addr);
        chk1("instr_valid", instr_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            chk("instr_pc", instr_pc, mq[0]);
            chk("instr", instr, memfn(mq[0]));
            chk("opcode", 32'(opcode), 32'(memfn(mq[0]) >> 26));
            chk("funct", 32'(funct), memfn(mq[0]) & 32'h3F);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drive(input bit a, input bit r);
        imem_ack    = a;
        instr_ready = r;
        jump        = 1'b0;
        imem_rdata  = a ? memfn(imem_addr) : $urandom();
    endtask

    task automatic set_jump(input logic [31:0] pc, input logic [25:0] idx);
        jump       = 1'b1;
        jump_pc    = pc;
        jump_index = idx;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
        jump        = 1'b0;
        jump_pc     = '0;
        jump_index  = '0;
        imem_rdata  = '0;
        model_reset();
        @(negedge clk);
        chk1("rst_req", imem_req, 1'b0);
        chk1("rst_valid", instr_valid, 1'b0);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);
        chk("rst_opfn", {20'b0, opcode, funct}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int acc;
        bit found;

        // Streaming with acks every cycle
        do_reset();
        drive(1, 1);
        tick();
        chk("st_addr0", imem_addr, 32'h0);
        chk1("st_req0", imem_req, 1'b1);
        drive(1, 1);
        tick();
        chk("st_pc0", instr_pc, 32'h0);
        chk("st_opcode", 32'(opcode), 32'h08);
        chk("st_funct", 32'(funct), 32'h05);
        chk("st_addr1", imem_addr, 32'h4);
        drive(1, 1);
        tick();
        chk("st_addr2", imem_addr, 32'h8);
        chk("st_pc1", instr_pc, 32'h4);
        for (int i = 0; i < 10; i++) begin
            drive(1, 1);
            tick();
        end

        // Backpressure
        do_reset();
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1, 0);
            if (imem_req) acc++;
            tick();
        end
        chk("bp_words", 32'(acc), 32'd2);
        chk1("bp_req_low", imem_req, 1'b0);
        chk("bp_head_pc", instr_pc, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            drive(1, 1);
            tick();
            if (imem_req) begin
                found = 1'b1;
                chk("bp_resume_addr", imem_addr, 32'h8);
            end
        end
        chk1("bp_resume_seen", found, 1'b1);
        for (int i = 0; i < 8; i++) begin
            drive(1, 1);
            tick();
        end

        // Jump while a request is outstanding
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            drive(1, 1);
            tick();
            if (imem_req && imem_addr == 32'h10) found = 1'b1;
        end
        chk1("jo_reach", found, 1'b1);
        drive(0, 1);
        set_jump(32'h0000_000C, 26'h40);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("jo_hold_addr", imem_addr, 32'h10);
            chk1("jo_valid_low", instr_valid, 1'b0);
            drive(0, 1);
            tick();
        end
        drive(1, 1);
        tick();
        chk("jo_target_addr", imem_addr, 32'h100);
        chk1("jo_valid_low2", instr_valid, 1'b0);
        drive(0, 1);
        tick();
        chk1("jo_valid_low3", instr_valid, 1'b0);
        drive(1, 0);
        tick();
        chk1("jo_valid_hi", instr_valid, 1'b1);
        chk("jo_first_pc", instr_pc, 32'h100);

        // Jump coincident with ack and pop
        drive(1, 1);
        set_jump(32'h0000_0040, 26'h123);
        tick();
        chk1("jc_flush", instr_valid, 1'b0);
        chk("jc_addr", imem_addr, 32'h0000_048C);

        // Target upper bits and PC wrap
        drive(1, 1);
        set_jump(32'hEFFF_FFFC, 26'h3FF_FFFF);
        tick();
        chk("wr_target", imem_addr, 32'hFFFF_FFFC);
        drive(1, 1);
        tick();
        chk("wr_next", imem_addr, 32'h0000_0000);
        chk("wr_head", instr_pc, 32'hFFFF_FFFC);

        // Async reset mid-fetch
        do_reset();
        drive(1, 0);
        tick();
        drive(1, 0);
        tick();
        chk1("ar_pre_valid", instr_valid, 1'b1);
        drive(0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("ar_req", imem_req, 1'b0);
        chk1("ar_valid", instr_valid, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0);
        tick();
        chk1("ar_restart_req", imem_req, 1'b1);
        chk("ar_restart_addr", imem_addr, RESET_PC);

        // Random traffic
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            drive(bit'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) set_jump($urandom() & 32'hFFFF_FFFC, 26'($urandom()));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
